// File: rtl/pipelined_fir_filter_if.sv
// Bundle of signals between a coefficient source / sample producer and the
// FIR filter.
//   master : drives coeffLoad, coeffInValid, coeffIn, flush, dataInValid,
//            dataIn; observes coeffSetFlag, dataInReady, dataOutValid, dataOut
//   slave  : the filter side (directions mirrored)
interface pipelined_fir_filter_if #(
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int GUARD_BITS  = 5
);
    localparam int OUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + GUARD_BITS;

    logic                           coeffLoad;
    logic                           coeffInValid;
    logic signed [COEFF_WIDTH-1:0]  coeffIn;
    logic                           coeffSetFlag;
    logic                           flush;
    logic                           dataInValid;
    logic                           dataInReady;
    logic signed [DATA_WIDTH-1:0]   dataIn;
    logic                           dataOutValid;
    logic signed [OUT_WIDTH-1:0]    dataOut;

    modport master (
        output coeffLoad, coeffInValid, coeffIn, flush, dataInValid, dataIn,
        input  coeffSetFlag, dataInReady, dataOutValid, dataOut
    );

    modport slave (
        input  coeffLoad, coeffInValid, coeffIn, flush, dataInValid, dataIn,
        output coeffSetFlag, dataInReady, dataOutValid, dataOut
    );
endinterface

// File: rtl/pipelined_fir_filter.sv
// Direct-form FIR filter with run-time coefficient loading, a valid/ready
// sample interface and a two-stage full-precision pipeline.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset
//   bus   : pipelined_fir_filter_if.slave (coefficient load, flush, sample
//           in with ready, result out with valid strobe)
// A sample accepted at edge E produces its result at edge E+2.
module pipelined_fir_filter #(
    parameter int LENGTH      = 20,
    parameter int DATA_WIDTH  = 18,
    parameter int COEFF_WIDTH = 18,
    parameter int GUARD_BITS  = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    pipelined_fir_filter_if.slave   bus
);
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int OUT_WIDTH  = PROD_WIDTH + GUARD_BITS;
    localparam int CNT_WIDTH  = $clog2(LENGTH);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_next_s;
    logic [CNT_WIDTH-1:0]           count_r;
    logic [CNT_WIDTH-1:0]           count_next_s;
    logic                           coeff_we_s;
    logic                           run_r;
    logic                           accept_s;
    logic signed [COEFF_WIDTH-1:0]  coeff_r [LENGTH];
    logic signed [DATA_WIDTH-1:0]   x_r     [LENGTH];
    logic signed [PROD_WIDTH-1:0]   prod_r  [LENGTH];
    logic                           acc_v_r;
    logic                           prod_v_r;
    logic                           out_v_r;
    logic signed [OUT_WIDTH-1:0]    sum_s;
    logic signed [OUT_WIDTH-1:0]    data_out_r;

    // A coefficient load on the same edge suppresses the sample accept.
    assign accept_s = bus.dataInValid & run_r & ~bus.coeffLoad;

    assign bus.dataInReady  = run_r;
    assign bus.coeffSetFlag = run_r;
    assign bus.dataOutValid = out_v_r;
    assign bus.dataOut      = data_out_r;

    // State and load-counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_WIDTH{1'b0}};
            run_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            run_r   <= (state_next_s == ST_RUN);
        end
    end

    // Next-state, load counter and coefficient write enable.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        coeff_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.coeffLoad) begin
                    state_next_s = ST_LOAD;
                    count_next_s = {CNT_WIDTH{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A fresh load pulse restarts the word count; words that
                // arrive with it are dropped.
                if (bus.coeffLoad) begin
                    count_next_s = {CNT_WIDTH{1'b0}};
                end else if (bus.coeffInValid) begin
                    coeff_we_s = 1'b1;
                    if (count_r == LAST_IDX) begin
                        state_next_s = ST_RUN;
                        count_next_s = {CNT_WIDTH{1'b0}};
                    end else begin
                        count_next_s = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    count_next_s = count_r;
                end
            end
            ST_RUN: begin
                if (bus.coeffLoad) begin
                    state_next_s = ST_LOAD;
                    count_next_s = {CNT_WIDTH{1'b0}};
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    // Coefficient store, written in order during a load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH; k++) begin
                coeff_r[k] <= {COEFF_WIDTH{1'b0}};
            end
        end else if (coeff_we_s) begin
            coeff_r[count_r] <= bus.coeffIn;
        end
    end

    // Sample delay line: cleared by load or flush, shifts only on accept.
    // A sample accepted with flush lands in an otherwise empty line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH; k++) begin
                x_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else if (bus.coeffLoad || bus.flush) begin
            for (int k = 0; k < LENGTH; k++) begin
                x_r[k] <= {DATA_WIDTH{1'b0}};
            end
            if (accept_s) begin
                x_r[0] <= bus.dataIn;
            end
        end else if (accept_s) begin
            x_r[0] <= bus.dataIn;
            for (int k = 1; k < LENGTH; k++) begin
                x_r[k] <= x_r[k-1];
            end
        end
    end

    // Stage 1: full-width tap products.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH; k++) begin
                prod_r[k] <= {PROD_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < LENGTH; k++) begin
                prod_r[k] <= $signed({{DATA_WIDTH{coeff_r[k][COEFF_WIDTH-1]}}, coeff_r[k]})
                           * $signed({{COEFF_WIDTH{x_r[k][DATA_WIDTH-1]}}, x_r[k]});
            end
        end
    end

    // Stage 2 adder tree input: sign-extended sum of all products.
    always_comb begin
        sum_s = {OUT_WIDTH{1'b0}};
        for (int k = 0; k < LENGTH; k++) begin
            sum_s = sum_s + $signed({{GUARD_BITS{prod_r[k][PROD_WIDTH-1]}}, prod_r[k]});
        end
    end

    // Valid tags follow the data; a load pulse kills everything in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_v_r    <= 1'b0;
            prod_v_r   <= 1'b0;
            out_v_r    <= 1'b0;
            data_out_r <= {OUT_WIDTH{1'b0}};
        end else begin
            acc_v_r  <= accept_s;
            prod_v_r <= acc_v_r & ~bus.coeffLoad;
            out_v_r  <= prod_v_r & ~bus.coeffLoad;
            if (prod_v_r && !bus.coeffLoad) begin
                data_out_r <= sum_s;
            end
        end
    end
endmodule
